// File: rtl/iir_sample_uart_tx_if.sv
// Sample stream port between the IIR filter output and the UART streamer.
// The filter drives data/valid; the streamer answers with ready (FIFO not full).
interface iir_sample_uart_tx_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/iir_sample_uart_tx.sv
// Buffers 16-bit filter samples in a FIFO and serializes each as UART 8N1 bytes, MSB byte first.
// Optional macro IIR_TX_FRAME_SYNC_EN prefixes every frame with the sync byte 0xA5.
module iir_sample_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_sample_uart_tx_if.slave  s,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
`ifdef IIR_TX_FRAME_SYNC_EN
    localparam int NUM_BYTES = 3;
    localparam int BYW       = 2;
`else
    localparam int NUM_BYTES = 2;
    localparam int BYW       = 1;
`endif
    localparam logic [BYW-1:0] LAST_BYTE = BYW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [15:0]   head;

    // Full when the low bits match but the wrap bits differ.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign push      = s.s_valid && !full;
    assign s.s_ready = !full;
    assign head      = mem[rd_ptr[AW-1:0]];

    // NOTE: sample storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s.s_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (s.s_valid && full) overflow <= 1'b1;
        end
    end

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d, baud_nxt;
    logic [2:0]     bit_q, bit_d;
    logic [BYW-1:0] byte_q, byte_d;
    logic [15:0]    sample_q, sample_d;
    logic           tx_q, tx_d;
    logic           baud_wrap;
    logic [7:0]     cur_byte;

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign baud_nxt  = baud_wrap ? '0 : baud_q + BW'(1);

    always_comb begin
`ifdef IIR_TX_FRAME_SYNC_EN
        case (byte_q)
            2'd0:    cur_byte = 8'hA5;
            2'd1:    cur_byte = sample_q[15:8];
            default: cur_byte = sample_q[7:0];
        endcase
`else
        cur_byte = byte_q[0] ? sample_q[7:0] : sample_q[15:8];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            sample_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            sample_q <= sample_d;
            tx_q     <= tx_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        sample_d = sample_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    sample_d = head;
                    byte_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                baud_d = baud_nxt;
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                baud_d = baud_nxt;
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_d];
                    end
                end
            end
            STOP: begin
                baud_d = baud_nxt;
                if (baud_wrap) begin
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + BYW'(1);
                        state_d = START;
                        tx_d    = 1'b0;
                    end else if (!empty) begin
                        // Back-to-back frame: next sample starts with no idle bit.
                        pop      = 1'b1;
                        sample_d = head;
                        byte_d   = '0;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_iir_sample_uart_tx.sv
// Self-checking bench for iir_sample_uart_tx: directed and random pushes against a frame-timing model.
// A second instance at the full 868-cycle baud divider checks bit spacing.
module tb_iir_sample_uart_tx;
    localparam int DIV   = 4;
    localparam int DEPTH = 8;
    localparam int DIV2  = 868;
`ifdef IIR_TX_FRAME_SYNC_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int FL  = NB * 10 * DIV;
    localparam int FL2 = NB * 10 * DIV2;

    logic clk = 1'b0;
    logic rst;
    logic tx, busy, overflow;
    logic tx2, busy2, overflow2;

    iir_sample_uart_tx_if sif ();
    iir_sample_uart_tx_if sif2 ();

    iir_sample_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s(sif), .tx(tx), .busy(busy), .overflow(overflow)
    );
    iir_sample_uart_tx #(.CLK_DIV(DIV2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .s(sif2), .tx(tx2), .busy(busy2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: per accepted sample, its push edge and the edge its frame starts.
    int          m_push[$];
    int          m_start[$];
    logic [15:0] m_data[$];
    logic        m_ovf;
    int          m2_start = -1;
    logic [15:0] m2_data;

    int   bad_tx, bad_busy, bad_rdy, bad_ovf, bad_tx2, busy_cycles, tx_toggles;
    logic tx_prev = 1'b1;
    logic tx2_prev = 1'b1;
    int   tx2_last = -1, first_fall = -1, start_w = -1, spacing_bad = 0;

    logic       rx_on = 1'b0;
    int         rx_t;
    logic [7:0] rx_sh;
    logic [7:0] rx_bytes[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [15:0] d, input int b);
        int bb = b;
`ifdef IIR_TX_FRAME_SYNC_EN
        if (bb == 0) return 8'hA5;
        bb = bb - 1;
`endif
        return (bb == 0) ? d[15:8] : d[7:0];
    endfunction

    // Line level at offset 'off' cycles into a frame: start 0, 8 data LSB first, stop 1 per byte.
    function automatic logic frame_bit(input logic [15:0] d, input int off, input int div);
        int j = off / div;
        int p = j % 10;
        logic [7:0] by = byte_of(d, j / 10);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    function automatic int count_after(input int e);
        int n = 0;
        foreach (m_push[k]) begin
            if (m_push[k] <= e) n++;
            if (m_start[k] <= e) n--;
        end
        return n;
    endfunction

    function automatic logic model_tx(input int e);
        foreach (m_start[k])
            if (m_start[k] <= e && e < m_start[k] + FL) return frame_bit(m_data[k], e - m_start[k], DIV);
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int e);
        foreach (m_push[k])
            if (m_push[k] <= e && e < m_start[k] + FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_tx2(input int e);
        if (m2_start >= 0 && m2_start <= e && e < m2_start + FL2)
            return frame_bit(m2_data, e - m2_start, DIV2);
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_push.delete();
        m_start.delete();
        m_data.delete();
        m_ovf    = 1'b0;
        m2_start = -1;
    endfunction

    // Accept if the FIFO held fewer than DEPTH entries before this edge; frames chain end to start.
    function automatic void model_push(input int e, input logic [15:0] d);
        int st;
        if (count_after(e - 1) < DEPTH) begin
            st = e + 1;
            if (m_start.size() > 0 && m_start[$] + FL > st) st = m_start[$] + FL;
            m_push.push_back(e);
            m_start.push_back(st);
            m_data.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (rst) model_reset();
        else begin
            if (sif.s_valid) model_push(edge_n, sif.s_data);
            if (sif2.s_valid) begin
                m2_start = edge_n + 1;
                m2_data  = sif2.s_data;
            end
        end
        @(negedge clk);
        if (tx !== model_tx(edge_n)) bad_tx++;
        if (busy !== model_busy(edge_n)) bad_busy++;
        if (sif.s_ready !== (count_after(edge_n) < DEPTH)) bad_rdy++;
        if (overflow !== m_ovf) bad_ovf++;
        if (tx2 !== model_tx2(edge_n)) bad_tx2++;
        if (busy === 1'b1) busy_cycles++;
        if (tx !== tx_prev) tx_toggles++;
        tx_prev = tx;
        if (tx2 !== tx2_prev) begin
            if (tx2_last >= 0 && ((edge_n - tx2_last) % DIV2) != 0) spacing_bad++;
            if (tx2 === 1'b0 && first_fall < 0) first_fall = edge_n;
            else if (tx2 === 1'b1 && first_fall >= 0 && start_w < 0) start_w = edge_n - first_fall;
            tx2_last = edge_n;
            tx2_prev = tx2;
        end
        // Mid-bit sampling UART receiver on the fast instance.
        if (rst) rx_on = 1'b0;
        else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % DIV == DIV / 2 && rx_t / DIV >= 1 && rx_t / DIV <= 8) rx_sh[rx_t/DIV-1] = tx;
            if (rx_t == 10 * DIV - 1) begin
                rx_on = 1'b0;
                rx_bytes.push_back(rx_sh);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tally_clear();
        bad_tx = 0; bad_busy = 0; bad_rdy = 0; bad_ovf = 0; bad_tx2 = 0;
        busy_cycles = 0; tx_toggles = 0;
        rx_bytes.delete();
    endtask

    task automatic check_tally(input string tag);
        check({tag, "_tx_wave"}, bad_tx, 0);
        check({tag, "_busy_wave"}, bad_busy, 0);
        check({tag, "_ready_wave"}, bad_rdy, 0);
        check({tag, "_ovf_wave"}, bad_ovf, 0);
    endtask

    task automatic check_bytes(input string tag, input logic [15:0] smp[$]);
        logic [7:0] exp_b[$];
        int bad = 0;
        foreach (smp[k]) for (int b = 0; b < NB; b++) exp_b.push_back(byte_of(smp[k], b));
        check({tag, "_nbytes"}, rx_bytes.size(), exp_b.size());
        foreach (exp_b[i]) if (i >= rx_bytes.size() || rx_bytes[i] !== exp_b[i]) bad++;
        check({tag, "_byte_values"}, bad, 0);
    endtask

    initial begin
        logic [15:0] pushed[$];
        rst = 1'b1;
        sif.s_valid = 1'b0;  sif.s_data = '0;
        sif2.s_valid = 1'b0; sif2.s_data = '0;
        tally_clear();
        run(3);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_ready", sif.s_ready, 1'b1);
        rst = 1'b0;
        run(2);

        // Single sample 0x1234.
        tally_clear();
        sif.s_valid = 1'b1; sif.s_data = 16'h1234;
        step();
        sif.s_valid = 1'b0;
        check("single_busy_after_push", busy, 1'b1);
        step();
        check("single_latency_tx_low", tx, 1'b0);
        run(FL + 20);
        check("single_nbytes", rx_bytes.size(), NB);
        check("single_byte_msb", rx_bytes[NB-2], 8'h12);
        check("single_byte_lsb", rx_bytes[NB-1], 8'h34);
        check("single_busy_cycles", busy_cycles, FL + 1);
        check_tally("single");

        // Back-to-back 0xFFFF, 0x8000.
        tally_clear();
        sif.s_valid = 1'b1; sif.s_data = 16'hFFFF;
        step();
        sif.s_data = 16'h8000;
        step();
        sif.s_valid = 1'b0;
        run(2 * FL + 20);
        check_bytes("b2b", '{16'hFFFF, 16'h8000});
        check("b2b_busy_cycles", busy_cycles, 2 * FL + 1);
        check_tally("b2b");

        // Overflow: ten consecutive valid cycles into an 8-deep FIFO.
        tally_clear();
        pushed.delete();
        for (int i = 1; i <= 10; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = 16'($urandom);
            pushed.push_back(sif.s_data);
            step();
            if (i == 9) check("ovf_ready_after_9th", sif.s_ready, 1'b0);
        end
        sif.s_valid = 1'b0;
        check("ovf_set", overflow, 1'b1);
        void'(pushed.pop_back());
        run(9 * FL + 20);
        check_bytes("ovf", pushed);
        check("ovf_sticky", overflow, 1'b1);
        check_tally("ovf");

        // Reset during DATA of the first sample byte.
        tally_clear();
        sif.s_valid = 1'b1; sif.s_data = 16'h5A5A;
        step();
        sif.s_valid = 1'b0;
        run((NB - 2) * 10 * DIV + 3 * DIV + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_overflow", overflow, 1'b0);
        check("rstmid_ready", sif.s_ready, 1'b1);
        tx_toggles = 0;
        run(200);
        check("rstmid_tx_toggles", tx_toggles, 0);
        check_tally("rstmid");

        // Random bursts, fast enough to overflow at times.
        tally_clear();
        for (int i = 0; i < 1500; i++) begin
            sif.s_valid = ($urandom_range(0, 29) == 0);
            sif.s_data  = 16'($urandom);
            step();
        end
        sif.s_valid = 1'b0;
        run((DEPTH + 1) * FL + 50);
        check_bytes("rand", m_data);
        check("rand_overflow", overflow, m_ovf);
        check_tally("rand");

`ifdef IIR_TX_FRAME_SYNC_EN
        tally_clear();
        sif.s_valid = 1'b1; sif.s_data = 16'h00A5;
        step();
        sif.s_valid = 1'b0;
        run(FL + 20);
        check_bytes("sync", '{16'h00A5});
        check("sync_busy_cycles", busy_cycles, FL + 1);
        check_tally("sync");
`endif

        // Full-rate divider: bit spacing and start-bit width.
        tally_clear();
        sif2.s_valid = 1'b1; sif2.s_data = 16'h5555;
        step();
        sif2.s_valid = 1'b0;
        run(FL2 + 100);
        check("baud_tx_wave", bad_tx2, 0);
        check("baud_edge_spacing", spacing_bad, 0);
        check("baud_start_width", start_w, DIV2);
        check("baud_busy_end", busy2, 1'b0);
        check("baud_overflow", overflow2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iir_sample_uart_tx.md
# iir_sample_uart_tx

Output-side streamer for the IIR filter pipeline. It accepts 16-bit signed filter output samples through a valid/ready port and buffers them in a small FIFO. Each sample is serialized as a UART 8N1 byte frame so the Python host testbench can capture filtered data over a single serial line. The block sits between the filter's `d_out` and the board's TX pin, opposite the host-to-FPGA sample path that feeds `d_in`.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `FIFO_DEPTH`, 8: sample FIFO entries. Power of two, minimum 2.
- Reset `rst` is synchronous and active-high; clock is `clk`.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `s_data`  in  16  sample (two's complement, Q1.15 or raw)
- `s_valid`  in  1  sample strobe, one sample per asserted cycle
- `s_ready`  out  1  FIFO not full
- `tx`  out  1  UART serial output, idle high
- `busy`  out  1  FSM not IDLE or FIFO non-empty
- `overflow`  out  1  sticky: a sample was dropped

## Operation
- **Push:**
  - `s_valid && s_ready` at an edge writes `s_data` into the FIFO.
  - `s_valid && !s_ready` drops the sample and sets `overflow`, which stays set until `rst`. The filter upstream cannot stall, so no retry is expected.
- **Full/pop interaction:** `s_ready = !full`, evaluated before any same-cycle pop. A full FIFO refuses a push even when a pop occurs in that cycle.
- **Frame:** each sample goes out as byte0 = `s_data[15:8]`, then byte1 = `s_data[7:0]` (MSB byte first).
  - Each byte is sent as start (0), 8 data bits LSB first, stop (1).
  - Bytes follow one another with no idle gap.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge: pop, load the byte sequencer, drive `tx` low.
  - START → DATA after CLK_DIV cycles. The 3-bit bit counter is cleared.
  - DATA → STOP after the 8th bit period.
  - STOP ends after CLK_DIV cycles:
    - more bytes remain in the frame → START with the next byte;
    - else FIFO non-empty → pop and go to START (back-to-back frames);
    - else → IDLE.
- **Baud counter:** counts 0..CLK_DIV-1 and wraps. A bit boundary is the wrap, so every bit lasts exactly CLK_DIV cycles.
- **FIFO:** pointers are log2(FIFO_DEPTH)+1 bits wide, and the full/empty decision uses the MSB. Pointers wrap modulo 2·FIFO_DEPTH.
- **Reset:** a reset mid-frame aborts the frame. On the next edge `tx` goes to 1, the FIFO is flushed, the FSM returns to IDLE and `overflow` clears. No partial byte completes.

## Timing
- **Reset values:**
  - `tx` = 1
  - `busy` = 0
  - `overflow` = 0
  - `s_ready` = 1 (FIFO empty)
- **Latency:** a sample accepted at edge N into an empty FIFO with the FSM in IDLE pops at edge N+1, and `tx` goes low from N+1.
- **Frame length:** 20·CLK_DIV cycles without sync, 30·CLK_DIV cycles with sync.
- **Sustained throughput:** one sample per frame length. Input faster than that fills the FIFO and then overflows.
- **`busy`:** high from the cycle after the first accepted push until the end of the last stop bit of the last buffered sample.

## Configuration
- `IIR_TX_FRAME_SYNC_EN` defined:
  - each frame is preceded by the sync byte 0xA5, giving 3 bytes per sample: 0xA5, MSB, LSB;
  - the byte sequencer counts 0..2.
- Not defined:
  - 2-byte frames only;
  - the byte sequencer counts 0..1;
  - no sync logic is synthesized.

## Test plan
- **Single sample:** CLK_DIV=4, macro off, push 0x1234 once.
  - `tx` = 0 for 4 cycles, then data bits 0,1,0,0,1,0,0,0, then 1 (byte 0x12).
  - Then 0, 0,0,1,0,1,1,0,0, 1 (byte 0x34), each bit 4 cycles.
  - `busy` drops after 80 cycles and `tx` stays 1.
- **Back-to-back samples:** push 0xFFFF then 0x8000 on consecutive cycles.
  - Bytes FF, FF, 80, 00 are sent with no idle cycle between frames.
  - Total 160 cycles at CLK_DIV=4.
- **Overflow:** CLK_DIV=4, FIFO_DEPTH=8, `s_valid` high for 10 consecutive cycles.
  - `s_ready` falls after the 9th accept; the 10th sample is dropped.
  - `overflow` = 1 and stays 1.
  - Exactly 9 frames are transmitted.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA of byte0.
  - `tx` = 1 on the next edge.
  - `busy` = 0, `overflow` = 0, `s_ready` = 1.
  - No further transitions on `tx`.
- **Sync on:** `IIR_TX_FRAME_SYNC_EN` defined, push 0x00A5.
  - Bytes 0xA5, 0x00, 0xA5 are sent; frame length 30·CLK_DIV.
- **Baud check:** CLK_DIV=868, push 0x5555.
  - Every `tx` edge is spaced by a multiple of 868 cycles.
  - Start-bit low width is exactly 868 cycles.
